alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameters: none; widths fixed (4-bit data, 2-bit op, 4-entry register file).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  controller accepts command this cycle.
REQ-006 cmd_ld  input  1  1 = load immediate, 0 = ALU operation.
REQ-007 cmd_op  input  2  ALU select: 00 NOT A, 01 A OR B, 10 A AND B, 11 A XOR B.
REQ-008 cmd_ra, cmd_rb, cmd_rd  input  2 each  source A, source B, destination register index.
REQ-009 cmd_imm  input  4  immediate for load.
REQ-010 alu_a, alu_b  output  4 each  registered operands to downstream ALU.
REQ-011 alu_s  output  2  registered ALU select.
REQ-012 alu_y  input  4  combinational ALU result, sampled by this block.
REQ-013 res_valid  output  1  result available; res_ready  input  1  consumer takes result.
REQ-014 res_data  output  4  result (ALU output or immediate).
REQ-015 dbg_sel  input  2, dbg_data  output  4  combinational read of register dbg_sel.

Function
REQ-016 FSM states IDLE, EXEC, RESP; cmd_ready = 1 only in IDLE.
REQ-017 Command accepted when cmd_valid & cmd_ready; all cmd_* fields captured that edge.
REQ-018 IDLE, accept, cmd_ld=0: alu_a <= reg[cmd_ra], alu_b <= reg[cmd_rb], alu_s <= cmd_op; -> EXEC.
REQ-019 IDLE, accept, cmd_ld=1: reg[cmd_rd] <= cmd_imm, res_data <= cmd_imm; -> RESP (EXEC skipped).
REQ-020 EXEC lasts exactly one cycle: at its end reg[rd] <= alu_y, res_data <= alu_y; -> RESP.
REQ-021 RESP: res_valid = 1; holds, res_data stable, until res_ready = 1, then -> IDLE.
REQ-022 Latency: op accepted at edge N -> res_valid high from N+2 (load: N+1); next command acceptable edge after res_ready handshake at earliest.
REQ-023 alu_a/alu_b/alu_s hold their last values outside EXEC; they change only on an accepted ALU command.
REQ-024 Operands read register contents before write-back; rd equal to ra or rb is legal, write occurs after read.
REQ-025 res_ready outside RESP is ignored; cmd_valid outside IDLE is ignored (no queuing).
REQ-026 All 4-bit values are unsigned; no carry, no overflow, no width extension.
REQ-027 dbg_data reflects register updates from the cycle after the write edge.

Reset
REQ-028 rst high at a clock edge: state -> IDLE, reg[0..3] = 0, alu_a = alu_b = 0, alu_s = 00, res_data = 0, res_valid = 0; cmd_ready = 1 after reset releases.
REQ-029 Reset in EXEC or RESP aborts the command: no write-back, result discarded, reset wins over simultaneous handshake.

Configuration
REQ-030 Macro ALU_CTRL_ZFLAG_EN defined: extra output res_zero (1 bit) = 1 when res_data == 4'h0, meaningful while res_valid, 0 after reset.
REQ-031 ALU_CTRL_ZFLAG_EN undefined: res_zero port and logic absent; all other behaviour identical.

Verification
REQ-032 LD r0=4'hA, LD r1=4'h6, XOR rd=r2 ra=r0 rb=r1 (bench ALU model) -> res_data 4'hC, dbg_sel=2 reads 4'hC, res_valid two cycles after accept.
REQ-033 NOT ra=r0 (4'hA) rd=r3 -> alu_s=00, alu_a=4'hA, res_data 4'h5, reg3 4'h5.
REQ-034 Back-pressure: result pending, res_ready low 3 cycles, cmd_valid high -> res_valid and res_data stable, cmd_ready 0, no extra command accepted; accepted the cycle after handshake.
REQ-035 rst asserted during EXEC of OR r0|r1 -> next cycle res_valid 0, cmd_ready 1, all registers and alu_* 0, no write-back.
REQ-036 Alias: AND ra=r0 rb=r0 rd=r0, r0=4'h9 -> res_data 4'h9, r0 stays 4'h9.
REQ-037 ZFLAG_EN build: AND 4'hA with 4'h5 -> res_data 4'h0, res_zero 1; OR same operands -> 4'hF, res_zero 0.

Source files
------------

// File: rtl/alu_ctrl.sv
// alu_ctrl: command controller for a small 4-bit ALU datapath.
//
// The block owns a 4-entry x 4-bit register file. It accepts one command at a
// time, presents registered operands and an op select to an external
// combinational ALU, then captures that ALU's result one cycle later. The
// result is written back to the register file and offered on a result port.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   cmd_valid/ready   command handshake (cmd_ready high only while idle)
//   cmd_ld            1 = load immediate, 0 = ALU operation
//   cmd_op            ALU select: 00 NOT A, 01 A|B, 10 A&B, 11 A^B
//   cmd_ra/rb/rd      source A, source B, destination register indices
//   cmd_imm           immediate value for loads
//   alu_a/b, alu_s    registered operands and select to the external ALU
//   alu_y             combinational result from the external ALU
//   res_valid/ready   result handshake
//   res_data          result (ALU output or immediate)
//   dbg_sel/dbg_data  combinational register file read
//   dbg_state         current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//   res_zero          only with ALU_CTRL_ZFLAG_EN defined: res_data == 0
//
// Optional feature macro: ALU_CTRL_ZFLAG_EN adds the res_zero output.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. Once res_valid rises, res_data is held stable until the
// transfer. cmd_valid outside IDLE and res_ready outside RESP are ignored.

module alu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_ld,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic [1:0] cmd_rd,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_s,
  input  logic [3:0] alu_y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  input  logic [1:0] dbg_sel,
  output logic [3:0] dbg_data,
  output logic [1:0] dbg_state
`ifdef ALU_CTRL_ZFLAG_EN
  ,
  output logic       res_zero
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] regs [4];
  logic [1:0] rd_q;   // destination of the ALU op in flight

  assign cmd_ready = (state == ST_IDLE);
  assign dbg_data  = regs[dbg_sel];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= 4'h0;
      alu_a     <= 4'h0;
      alu_b     <= 4'h0;
      alu_s     <= 2'b00;
      res_data  <= 4'h0;
      res_valid <= 1'b0;
      rd_q      <= 2'b00;
`ifdef ALU_CTRL_ZFLAG_EN
      res_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_ld) begin
              // Loads need no ALU cycle: write and respond directly.
              regs[cmd_rd] <= cmd_imm;
              res_data     <= cmd_imm;
              res_valid    <= 1'b1;
`ifdef ALU_CTRL_ZFLAG_EN
              res_zero     <= (cmd_imm == 4'h0);
`endif
              state        <= ST_RESP;
            end else begin
              // Operands are read here, before any write-back, so rd may
              // alias ra or rb.
              alu_a <= regs[cmd_ra];
              alu_b <= regs[cmd_rb];
              alu_s <= cmd_op;
              rd_q  <= cmd_rd;
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          regs[rd_q] <= alu_y;
          res_data   <= alu_y;
          res_valid  <= 1'b1;
`ifdef ALU_CTRL_ZFLAG_EN
          res_zero   <= (alu_y == 4'h0);
`endif
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Testbench for alu_ctrl: directed scenarios plus randomized command streams
// checked against a register-file model and a downstream ALU model.

module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_ld = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_ra = 2'b00;
  logic [1:0] cmd_rb = 2'b00;
  logic [1:0] cmd_rd = 2'b00;
  logic [3:0] cmd_imm = 4'h0;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_s;
  logic [3:0] alu_y;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic [1:0] dbg_sel = 2'b00;
  logic [3:0] dbg_data;
  logic [1:0] dbg_state;
`ifdef ALU_CTRL_ZFLAG_EN
  logic       res_zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference register file and expected-result queue.
  logic [3:0] m_regs [4];
  logic [3:0] exp_q [$];

  alu_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ld(cmd_ld), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_state(dbg_state)
`ifdef ALU_CTRL_ZFLAG_EN
    , .res_zero(res_zero)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Downstream ALU and reference operation, straight from the op table.
  function automatic logic [3:0] ref_op(input logic [1:0] op,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
    case (op)
      2'd0:    return ~a;
      2'd1:    return a | b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_y = ref_op(alu_s, alu_a, alu_b);

  // Model: apply one command, push the expected result, return it.
  task automatic model_apply(input logic ld, input logic [1:0] op,
                             input logic [1:0] ra, input logic [1:0] rb,
                             input logic [1:0] rd, input logic [3:0] imm);
    logic [3:0] r;
    r = ld ? imm : ref_op(op, m_regs[ra], m_regs[rb]);
    m_regs[rd] = r;
    exp_q.push_back(r);
  endtask

  // ---------------- driver ----------------
  // Issues one command, waits for the result, optionally stalls res_ready,
  // then completes the handshake. Returns observations; lat = 99 on timeout.
  task automatic run_cmd(input logic ld, input logic [1:0] op,
                         input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rd, input logic [3:0] imm,
                         input int stall,
                         output int lat, output logic [3:0] data,
                         output logic [3:0] oa, output logic [3:0] ob,
                         output logic [1:0] os, output logic rdy_after);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin @(posedge clk); #1; w++; end
    cmd_valid = 1'b1; cmd_ld = ld; cmd_op = op;
    cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    oa = alu_a; ob = alu_b; os = alu_s;
    lat = 0;
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!res_valid) lat = 99;
    data = res_data;
    repeat (stall) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    rdy_after = cmd_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
    n_checks++;
    if ({res_valid, cmd_ready, alu_a, alu_b, alu_s, res_data} !== {1'b0, 1'b1, 14'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b ready=%b a=%h b=%h s=%b data=%h, want 0 1 0 0 00 0",
               res_valid, cmd_ready, alu_a, alu_b, alu_s, res_data);
    end
`ifdef ALU_CTRL_ZFLAG_EN
    n_checks++;
    if (res_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_zero: got %b want 0", res_zero);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_checks++;
      if (dbg_data !== 4'h0) begin
        n_fail++; $display("FAIL reset_reg%0d: got %h want 0", i, dbg_data);
      end
    end
  endtask

  task automatic test_directed();
    int lat; logic [3:0] d, oa, ob; logic [1:0] os; logic ra;
    run_cmd(1, 0, 0, 0, 0, 4'hA, 0, lat, d, oa, ob, os, ra);
    model_apply(1, 0, 0, 0, 0, 4'hA); void'(exp_q.pop_front());
    n_checks++;
    if (lat !== 0 || d !== 4'hA) begin
      n_fail++; $display("FAIL ld_r0: got lat=%0d data=%h want lat=0 data=a", lat, d);
    end
    run_cmd(1, 0, 0, 0, 1, 4'h6, 0, lat, d, oa, ob, os, ra);
    model_apply(1, 0, 0, 0, 1, 4'h6); void'(exp_q.pop_front());
    run_cmd(0, 3, 0, 1, 2, 4'h0, 0, lat, d, oa, ob, os, ra);
    model_apply(0, 3, 0, 1, 2, 4'h0); void'(exp_q.pop_front());
    dbg_sel = 2'd2; #1;
    n_checks++;
    if (lat !== 1 || d !== 4'hC || dbg_data !== 4'hC || ra !== 1'b1) begin
      n_fail++;
      $display("FAIL xor_seq: got lat=%0d data=%h reg2=%h ready=%b want lat=1 data=c reg2=c ready=1",
               lat, d, dbg_data, ra);
    end
    run_cmd(0, 0, 0, 2, 3, 4'h0, 0, lat, d, oa, ob, os, ra);
    model_apply(0, 0, 0, 2, 3, 4'h0); void'(exp_q.pop_front());
    dbg_sel = 2'd3; #1;
    n_checks++;
    if (os !== 2'b00 || oa !== 4'hA || d !== 4'h5 || dbg_data !== 4'h5) begin
      n_fail++;
      $display("FAIL not_seq: got s=%b a=%h data=%h reg3=%h want s=00 a=a data=5 reg3=5",
               os, oa, d, dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] held;
    int w;
    // OR r0|r1 (a|6 = e) into r2, then stall with a load waiting.
    cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_op = 2'd1;
    cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rd = 2'd2;
    @(posedge clk); #1;
    model_apply(0, 1, 0, 1, 2, 4'h0);
    // A different command stays presented while the result is pending.
    cmd_ld = 1'b1; cmd_rd = 2'd3; cmd_imm = 4'h7;
    w = 0;
    while (!res_valid && w < 10) begin @(posedge clk); #1; w++; end
    held = exp_q.pop_front();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== held || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_c%0d: got valid=%b data=%h ready=%b want 1 %h 0",
                 c, res_valid, res_data, cmd_ready, held);
      end
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL handshake: got valid=%b ready=%b want 0 1", res_valid, cmd_ready);
    end
    // The waiting load is taken on the very next edge.
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_apply(1, 0, 0, 0, 3, 4'h7);
    held = exp_q.pop_front();
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== held) begin
      n_fail++; $display("FAIL after_handshake: got valid=%b data=%h want 1 %h", res_valid, res_data, held);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    dbg_sel = 2'd2; #1;
    n_checks++;
    if (dbg_data !== m_regs[2]) begin
      n_fail++; $display("FAIL or_writeback: got %h want %h", dbg_data, m_regs[2]);
    end
  endtask

  task automatic test_reset_in_exec();
    cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_op = 2'd1;
    cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rd = 2'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
    n_checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 4'h0 || alu_b !== 4'h0 || alu_s !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_exec: got valid=%b ready=%b a=%h b=%h s=%b want 0 1 0 0 00",
               res_valid, cmd_ready, alu_a, alu_b, alu_s);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_checks++;
      if (dbg_data !== 4'h0) begin
        n_fail++; $display("FAIL rst_exec_reg%0d: got %h want 0", i, dbg_data);
      end
    end
    // Nothing should emerge later either.
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_exec_late: got valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_alias();
    int lat; logic [3:0] d, oa, ob; logic [1:0] os; logic ra;
    run_cmd(1, 0, 0, 0, 0, 4'h9, 0, lat, d, oa, ob, os, ra);
    model_apply(1, 0, 0, 0, 0, 4'h9); void'(exp_q.pop_front());
    run_cmd(0, 2, 0, 0, 0, 4'h0, 1, lat, d, oa, ob, os, ra);
    model_apply(0, 2, 0, 0, 0, 4'h0); void'(exp_q.pop_front());
    dbg_sel = 2'd0; #1;
    n_checks++;
    if (d !== 4'h9 || dbg_data !== 4'h9) begin
      n_fail++; $display("FAIL alias: got data=%h r0=%h want 9 9", d, dbg_data);
    end
  endtask

  task automatic test_random();
    int lat; logic [3:0] d, oa, ob, pa, pb, e; logic [1:0] os, ps; logic ra;
    logic ld; logic [1:0] op, s_a, s_b, s_d; logic [3:0] imm;
    for (int n = 0; n < 60; n++) begin
      ld = ($urandom_range(0, 2) == 0); op = 2'($urandom_range(0, 3));
      s_a = 2'($urandom_range(0, 3)); s_b = 2'($urandom_range(0, 3));
      s_d = 2'($urandom_range(0, 3)); imm = 4'($urandom_range(0, 15));
      pa = alu_a; pb = alu_b; ps = alu_s;
      if (!ld) begin
        pa = m_regs[s_a]; pb = m_regs[s_b]; ps = op;
      end
      model_apply(ld, op, s_a, s_b, s_d, imm);
      e = exp_q.pop_front();
      run_cmd(ld, op, s_a, s_b, s_d, imm, $urandom_range(0, 3), lat, d, oa, ob, os, ra);
      dbg_sel = s_d; #1;
      n_checks++;
      if (d !== e || lat !== (ld ? 0 : 1) || {oa, ob, os} !== {pa, pb, ps}
          || dbg_data !== e || ra !== 1'b1) begin
        n_fail++;
        $display("FAIL random_%0d: got data=%h lat=%0d ops=%h/%h/%b reg=%h ready=%b want %h %0d %h/%h/%b %h 1",
                 n, d, lat, oa, ob, os, dbg_data, ra, e, ld ? 0 : 1, pa, pb, ps, e);
      end
    end
  endtask

`ifdef ALU_CTRL_ZFLAG_EN
  task automatic test_zflag();
    int lat; logic [3:0] d, oa, ob; logic [1:0] os; logic ra; logic z;
    run_cmd(1, 0, 0, 0, 0, 4'hA, 0, lat, d, oa, ob, os, ra);
    run_cmd(1, 0, 0, 0, 1, 4'h5, 0, lat, d, oa, ob, os, ra);
    // Capture res_zero while the result is valid, before the handshake.
    cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_op = 2'd2;
    cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rd = 2'd2;
    repeat (2) @(posedge clk); #1;
    cmd_valid = 1'b0; z = res_zero; d = res_data;
    res_ready = 1'b1; @(posedge clk); #1; res_ready = 1'b0;
    n_checks++;
    if (d !== 4'h0 || z !== 1'b1) begin
      n_fail++; $display("FAIL zflag_and: got data=%h zero=%b want 0 1", d, z);
    end
    cmd_valid = 1'b1; cmd_op = 2'd1;
    repeat (2) @(posedge clk); #1;
    cmd_valid = 1'b0; z = res_zero; d = res_data;
    res_ready = 1'b1; @(posedge clk); #1; res_ready = 1'b0;
    n_checks++;
    if (d !== 4'hF || z !== 1'b0) begin
      n_fail++; $display("FAIL zflag_or: got data=%h zero=%b want f 0", d, z);
    end
    m_regs[0] = 4'hA; m_regs[1] = 4'h5; m_regs[2] = 4'hF;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_exec();
    test_alias();
`ifdef ALU_CTRL_ZFLAG_EN
    test_zflag();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard ceiling in case a wait loop is ever mis-bounded.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
